// File: rtl/lsu_pkg.sv
// Purpose: shared types and helpers for the load/store unit (state encoding, RV32I width codes).
// Latency: n/a (package only).
// Backpressure: n/a.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD_RD,
        LD_CAP,
        ST_WR,
        RMW_RD,
        RMW_CAP,
        RMW_WR,
        RESP
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // Stores only have signed-agnostic B/H/W; loads add the unsigned B/H forms.
    function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!store) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return !ok;
    endfunction

    // f3[1:0] encodes the access size for every legal code: 00 byte, 01 half, 10 word.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        if (f3[1:0] == 2'b01) begin
            bad = addr_lo[0];
        end else if (f3[1:0] == 2'b10) begin
            bad = (addr_lo != 2'b00);
        end
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Purpose: byte/half lane extract with sign/zero extension, and sub-word merge for stores.
// Latency: combinational.
// Backpressure: none.
// Ports: word (memory word), addr_lo (byte offset), funct3 (width/sign),
//        wdata (store data low half), ld_data (extended load result), st_merged (merged word).
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [15:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_merged
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Little-endian: byte lane n lives in bits [8n+7:8n].
    always_comb begin
        lane_b = word[{addr_lo, 3'b000} +: 8];
        lane_h = addr_lo[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        ld_data = word;
        case (funct3)
            F3_B:    ld_data = {{24{lane_b[7]}}, lane_b};
            F3_H:    ld_data = {{16{lane_h[15]}}, lane_h};
            F3_BU:   ld_data = {24'h0, lane_b};
            F3_HU:   ld_data = {16'h0, lane_h};
            default: ld_data = word;
        endcase
    end

    always_comb begin
        st_merged = word;
        if (funct3 == F3_B) begin
            st_merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
        end else if (funct3 == F3_H) begin
            if (addr_lo[1]) begin
                st_merged[31:16] = wdata;
            end else begin
                st_merged[15:0] = wdata;
            end
        end
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Purpose: single-outstanding load/store initiator to a word-organised memory; sub-word stores via read-modify-write.
// Latency: accept edge to resp_valid: error 1, SW 2, load 3, SB/SH 4 cycles.
// Backpressure: req_ready only in IDLE; resp_valid held until resp_ready, no new accept in that cycle.
// Ports: req_* byte-addressed request in, resp_* result out,
//        mem_* word-indexed strobes/data to memory (mem_rdata valid the cycle after mem_read).
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int MEMSIZE = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state_q;
    lsu_state_t  state_d;

    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;
    logic [31:0] resp_data_q;
    logic        resp_err_q;

    logic        req_bad;
    logic        accept;
    logic [31:0] lane_ld;
    logic [31:0] lane_merged;

    always_comb begin
        req_bad = f3_illegal(req_store, req_funct3)
               || misaligned(req_funct3, req_addr[1:0])
               || ({2'b00, req_addr[31:2]} >= 32'(MEMSIZE));
        accept  = (state_q == IDLE) && req_valid;
    end

    // Lane logic always sees the live read data; results are only
    // registered in the capture states, where mem_rdata is valid.
    lsu_lane u_lane (
        .word      (mem_rdata),
        .addr_lo   (addr_q[1:0]),
        .funct3    (f3_q),
        .wdata     (wdata_q[15:0]),
        .ld_data   (lane_ld),
        .st_merged (lane_merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_wdata  = 32'h0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_bad) begin
                        state_d = RESP;
                    end else if (!req_store) begin
                        state_d = LD_RD;
                    end else if (req_funct3 == F3_W) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            LD_RD: begin
                mem_read = 1'b1;
                state_d  = LD_CAP;
            end
            LD_CAP: begin
                state_d = RESP;
            end
            ST_WR: begin
                mem_write = 1'b1;
                mem_wdata = wdata_q;
                state_d   = RESP;
            end
            RMW_RD: begin
                mem_read = 1'b1;
                state_d  = RMW_CAP;
            end
            RMW_CAP: begin
                state_d = RMW_WR;
            end
            RMW_WR: begin
                mem_write = 1'b1;
                mem_wdata = merge_q;
                state_d   = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f3_q        <= 3'h0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            merge_q     <= 32'h0;
            resp_data_q <= 32'h0;
            resp_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                f3_q        <= req_funct3;
                addr_q      <= req_addr;
                wdata_q     <= req_wdata;
                resp_data_q <= 32'h0;
                resp_err_q  <= req_bad;
            end
            if (state_q == LD_CAP) begin
                resp_data_q <= lane_ld;
            end
            if (state_q == RMW_CAP) begin
                merge_q <= lane_merged;
            end
        end
    end

    always_comb begin
        mem_addr  = {2'b00, addr_q[31:2]};
        resp_data = resp_data_q;
        resp_err  = resp_err_q;
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'h0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    lsu_ctrl #(.MEMSIZE(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Environment memory: registered read, synchronous write.
    logic [31:0] tbmem [64];
    logic [31:0] rdata_r = 32'h0;
    assign mem_rdata = rdata_r;
    always @(posedge clk) begin
        if (mem_read)  rdata_r <= tbmem[mem_addr[5:0]];
        if (mem_write) tbmem[mem_addr[5:0]] <= mem_wdata;
    end

    // Reference model: flat byte-addressed memory.
    logic [7:0] ref_mem [256];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic set_word(input int idx, input logic [31:0] val);
        tbmem[idx] = val;
        for (int k = 0; k < 4; k++) ref_mem[idx*4 + k] = 8'((val >> (8*k)) & 32'hFF);
    endtask

    function automatic logic [31:0] ref_word(input int idx);
        logic [31:0] w;
        w = 0;
        for (int k = 0; k < 4; k++) w = w + (32'(ref_mem[idx*4 + k]) << (8*k));
        return w;
    endfunction

    task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output logic [31:0] got_data);
        int          size;
        bit          legal, bad;
        int          exp_lat, exp_rd, exp_wr, lat, nr, nw;
        logic [31:0] v, exp_data, exp_word;
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        bad   = !legal || (a % size != 0) || (a >= 256);
        exp_lat  = bad ? 1 : !st ? 3 : (size == 4) ? 2 : 4;
        exp_rd   = (!bad && (!st || size < 4)) ? 1 : 0;
        exp_wr   = (!bad && st) ? 1 : 0;
        exp_data = 0;
        exp_word = 0;
        if (!bad && !st) begin
            v = 0;
            for (int k = 0; k < size; k++) v = v + (32'(ref_mem[a + k]) << (8*k));
            if (f3 == 3'd0 && v >= 128)        exp_data = v - 256;
            else if (f3 == 3'd1 && v >= 32768) exp_data = v - 65536;
            else                               exp_data = v;
        end
        if (!bad && st) begin
            for (int k = 0; k < size; k++) ref_mem[a + k] = 8'((wd >> (8*k)) & 32'hFF);
            exp_word = ref_word(int'(a >> 2));
        end

        check("req_ready_idle", req_ready, 1);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1; nr = 0; nw = 0;
        forever begin
            if (mem_read || mem_write) begin
                check("strobe_excl", 32'(mem_read & mem_write), 0);
                check("mem_addr", mem_addr, a >> 2);
            end
            if (mem_read) nr++;
            if (mem_write) begin
                nw++;
                check("mem_wdata", mem_wdata, exp_word);
            end
            if (resp_valid || lat >= 20) break;
            @(posedge clk); #1;
            lat++;
        end
        check("resp_valid", resp_valid, 1);
        check("latency", lat, exp_lat);
        check("resp_err", resp_err, bad);
        check("resp_data", resp_data, exp_data);
        check("n_read", nr, exp_rd);
        check("n_write", nw, exp_wr);
        got_data = resp_data;
        @(posedge clk); #1;
        check("resp_drop", resp_valid, 0);
    endtask

    logic [31:0] d, held;
    int          waitc;
    logic [31:0] ra;

    initial begin
        for (int i = 0; i < 64; i++) set_word(i, $urandom);

        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        #12 rst_n = 1'b1;
        @(posedge clk); #1;

        // Lane extraction with sign/zero extension.
        set_word(3, 32'h80FF_7F01);
        run_req(0, 3'd0, 32'h0C, 0, d); check("lb_0c", d, 32'h0000_0001);
        run_req(0, 3'd0, 32'h0F, 0, d); check("lb_0f", d, 32'hFFFF_FF80);
        run_req(0, 3'd4, 32'h0F, 0, d); check("lbu_0f", d, 32'h0000_0080);

        // Sub-word store via read-modify-write.
        set_word(3, 32'h1234_5678);
        run_req(1, 3'd0, 32'h0D, 32'h0000_00AA, d);
        check("sb_mem", tbmem[3], 32'h1234_AA78);

        run_req(1, 3'd2, 32'h10, 32'hDEAD_BEEF, d);
        check("sw_mem", tbmem[4], 32'hDEAD_BEEF);
        run_req(0, 3'd1, 32'h12, 0, d); check("lh_12", d, 32'hFFFF_DEAD);

        // Error cases.
        run_req(0, 3'd2, 32'h06, 0, d);
        run_req(1, 3'd1, 32'h03, 32'h1111, d);
        run_req(0, 3'd3, 32'h00, 0, d);
        run_req(0, 3'd2, 32'h100, 0, d);
        run_req(1, 3'd4, 32'h08, 32'h22, d);

        // Response held under backpressure; a second request must wait.
        set_word(7, 32'h89AB_CDEF);
        resp_ready = 1'b0;
        req_valid  = 1'b1; req_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h1C;
        @(posedge clk); #1;
        req_addr = 32'h20; req_funct3 = 3'd0;
        waitc = 0;
        while (!resp_valid && waitc < 10) begin
            @(posedge clk); #1; waitc++;
        end
        check("stall_valid", resp_valid, 1);
        check("stall_data", resp_data, 32'h89AB_CDEF);
        held = resp_data;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall_hold_valid", resp_valid, 1);
            check("stall_hold_data", resp_data, held);
            check("stall_req_ready", req_ready, 0);
            check("stall_no_mem", 32'(mem_read | mem_write), 0);
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_release", resp_valid, 0);
        check("stall_idle", req_ready, 1);

        // Reset during RMW_CAP aborts the store.
        set_word(5, 32'hCAFE_F00D);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd0; req_addr = 32'h15; req_wdata = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("arst_req_ready", req_ready, 1);
        check("arst_resp_valid", resp_valid, 0);
        check("arst_mem_write", mem_write, 0);
        check("arst_mem_read", mem_read, 0);
        check("arst_mem_addr", mem_addr, 0);
        check("arst_mem_wdata", mem_wdata, 0);
        check("arst_resp_data", resp_data, 0);
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("arst_no_resp", resp_valid, 0);
        end
        check("arst_mem_kept", tbmem[5], 32'hCAFE_F00D);

        // Randomized traffic against the byte-level model.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) ra = $urandom;
            else ra = 32'($urandom_range(0, 255));
            run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom, d);
        end
        for (int i = 0; i < 64; i++) check("final_mem", tbmem[i], ref_word(i));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
